// File: rtl/line_memory_responder.sv
// Wishbone slave that stands in for physical memory behind the L1 cache:
// one 128-bit line transaction at a time, fixed latency, single-cycle ACK.
module line_memory_responder #(
    parameter int LATENCY = 4,
    parameter int LINES   = 256
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CYC,
    input  logic         STB,
    input  logic         WE,
    input  logic [11:0]  ADR,
    input  logic [15:0]  SEL,
    input  logic [127:0] DAT_M,
    output logic [127:0] DAT_S,
    output logic         ACK
);

    localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_RECOVER
    } state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [IDX_W-1:0]   lat_idx;
    logic               lat_we;
    logic [15:0]        lat_sel;
    logic [127:0]       lat_dat;

    logic [127:0]       mem [LINES];

    logic               req;
    logic               enter_resp;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_we;
    logic               unused_adr_hi;

    assign req = CYC && STB;

    // Upper address bits alias onto the same lines and are intentionally unused.
    assign unused_adr_hi = ^ADR;

    // Entering RESP on this edge; with LATENCY = 1 the sample edge itself does it.
    always_comb begin
        enter_resp = 1'b0;
        rd_idx     = lat_idx;
        rd_we      = lat_we;
        if (state == S_IDLE) begin
            rd_idx     = ADR[IDX_W-1:0];
            rd_we      = WE;
            enter_resp = req && (LATENCY == 1);
        end else if (state == S_WAIT) begin
            enter_resp = req && (cnt == 4'd0);
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            lat_idx <= '0;
            lat_we  <= 1'b0;
            lat_sel <= 16'h0000;
            lat_dat <= '0;
            ACK     <= 1'b0;
            DAT_S   <= '0;
        end else begin
            ACK   <= enter_resp;
            DAT_S <= (enter_resp && !rd_we) ? mem[rd_idx] : '0;
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_idx <= ADR[IDX_W-1:0];
                        lat_we  <= WE;
                        lat_sel <= SEL;
                        lat_dat <= DAT_M;
                        // Counts remaining WAIT edges; zero means the next held edge enters RESP.
                        cnt     <= 4'(LATENCY - 2);
                        state   <= (LATENCY == 1) ? S_RESP : S_WAIT;
                        if (LATENCY == 1) cnt <= 4'd0;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_RECOVER;
                end
                S_RECOVER: begin
                    if (!req) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the line array is deliberately not reset; only the write strobe is
    // qualified by RST so an in-flight write is discarded.
    always_ff @(posedge CLK) begin
        if (!RST && state == S_RESP && lat_we) begin
            for (int i = 0; i < 16; i++) begin
                if (lat_sel[i]) mem[lat_idx][8*i +: 8] <= lat_dat[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_line_memory_responder.sv
// Self-checking bench for line_memory_responder: directed steps plus a random
// transaction phase checked against a line-array reference model.
module tb_line_memory_responder;

    localparam int LATENCY = 4;
    localparam int LINES   = 256;

    logic         CLK = 1'b0;
    logic         RST, CYC, STB, WE;
    logic [11:0]  ADR;
    logic [15:0]  SEL;
    logic [127:0] DAT_M, DAT_S;
    logic         ACK;

    int errors = 0;
    int checks = 0;

    logic [127:0] exp_mem [LINES];

    line_memory_responder #(.LATENCY(LATENCY), .LINES(LINES)) dut (
        .CLK(CLK), .RST(RST), .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR),
        .SEL(SEL), .DAT_M(DAT_M), .DAT_S(DAT_S), .ACK(ACK)
    );

    always #5 CLK = ~CLK;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [11:0] adr, input logic [15:0] sel, input logic [127:0] dat);
        int idx;
        idx = int'(adr) % LINES;
        for (int i = 0; i < 16; i++)
            if (sel[i]) exp_mem[idx][8*i +: 8] = dat[8*i +: 8];
    endtask

    task automatic idle_checks(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            check(tag, ACK, 1'b0);
            check({tag, "_dat"}, DAT_S, '0);
        end
    endtask

    // Called between a negedge and the next posedge; that posedge is the sample edge.
    task automatic txn(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                       input logic [127:0] dat, input int hold, output logic [127:0] rdata);
        logic [127:0] expd;
        expd = exp_mem[int'(adr) % LINES];
        rdata = '0;
        CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; SEL = sel; DAT_M = dat;
        @(posedge CLK);
        for (int k = 1; k <= LATENCY; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                WE = 1'($urandom); ADR = 12'($urandom); SEL = 16'($urandom); DAT_M = rand128();
            end
            if (k < LATENCY) begin
                check("ack_early", ACK, 1'b0);
                check("dat_without_ack", DAT_S, '0);
            end else begin
                check("ack_on_time", ACK, 1'b1);
                rdata = DAT_S;
                if (!we) check("read_data", DAT_S, expd);
            end
        end
        if (we) model_write(adr, sel, dat);
        idle_checks("ack_single", hold);
        CYC = 1'b0; STB = 1'b0;
        idle_checks("ack_after_drop", 2);
    endtask

    initial begin
        logic [127:0] rd, wdat;
        logic [11:0]  radr;
        for (int i = 0; i < LINES; i++) exp_mem[i] = '0;

        // Reset held with a live request: nothing may respond.
        RST = 1'b1; CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 12'h000;
        SEL = 16'hFFFF; DAT_M = rand128();
        idle_checks("reset_ack", 2);
        RST = 1'b0;
        txn(1'b1, 12'h000, 16'hFFFF, rand128(), 0, rd);

        for (int i = 0; i < LINES; i++) txn(1'b1, 12'(i), 16'hFFFF, rand128(), 0, rd);

        wdat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        txn(1'b1, 12'h010, 16'hFFFF, wdat, 0, rd);
        txn(1'b0, 12'h010, 16'h0000, '0, 0, rd);
        check("full_write_read", rd, wdat);

        txn(1'b1, 12'h020, 16'hFFFF, {128{1'b1}}, 0, rd);
        txn(1'b1, 12'h020, 16'h00F0, '0, 0, rd);
        txn(1'b0, 12'h020, 16'hFFFF, '0, 0, rd);
        check("partial_write", rd, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_FFFF_FFFF);

        // Zero-lane write completes but changes nothing.
        txn(1'b1, 12'h021, 16'h0000, rand128(), 0, rd);
        txn(1'b0, 12'h021, 16'h0000, '0, 0, rd);

        txn(1'b0, 12'h040, 16'h0000, '0, 3, rd);
        txn(1'b0, 12'h041, 16'h0000, '0, 0, rd);

        // Abort: strobe dropped two cycles after the sample edge.
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 12'h030; SEL = 16'hFFFF; DAT_M = rand128();
        @(posedge CLK);
        idle_checks("abort_early", 1);
        @(negedge CLK);
        CYC = 1'b0; STB = 1'b0;
        idle_checks("abort_no_ack", LATENCY + 2);
        txn(1'b0, 12'h030, 16'h0000, '0, 0, rd);

        wdat = rand128();
        txn(1'b1, 12'h105, 16'hFFFF, wdat, 0, rd);
        txn(1'b0, 12'h005, 16'h0000, '0, 0, rd);
        check("alias_read", rd, wdat);

        // Reset during WAIT of a write: write discarded, no ACK.
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 12'h006; SEL = 16'hFFFF; DAT_M = rand128();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        idle_checks("reset_mid_write", 2);
        CYC = 1'b0; STB = 1'b0; RST = 1'b0;
        idle_checks("after_reset_no_ack", LATENCY + 2);
        txn(1'b0, 12'h006, 16'h0000, '0, 0, rd);

        for (int n = 0; n < 60; n++) begin
            radr = 12'($urandom_range(0, 4095));
            txn(1'($urandom), radr, 16'($urandom), rand128(), $urandom_range(0, 2), rd);
        end
        for (int n = 0; n < 10; n++) txn(1'b0, 12'($urandom), 16'h0000, '0, 0, rd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
